// File: rtl/serial_sub8.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub8
//  Brief    : Bit-serial 8-bit subtractor, diff = ain - bin - brin, LSB first,
//             with valid/ready handshakes on operands and result.
//             Optional signed-overflow output under SERIAL_SUB8_OVF_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_sub8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] ain,
    input  logic [7:0] bin,
    input  logic       brin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] diff,
    output logic       bout
`ifdef SERIAL_SUB8_OVF_EN
    ,
    output logic       ovf
`endif
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [7:0] r_a_sr;
    logic [7:0] r_b_sr;
    logic       r_br;
    logic [2:0] r_cnt;
    logic [7:0] r_diff;
    logic       r_bout;
    logic       w_d;
    logic       w_br_next;
    logic       w_last;

    assign w_d       = r_a_sr[0] ^ r_b_sr[0] ^ r_br;
    assign w_br_next = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_br);
    assign w_last    = (r_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (in_valid)  w_state_next = c_SHIFT;
            c_SHIFT: if (w_last)    w_state_next = c_DONE;
            c_DONE:  if (out_ready) w_state_next = c_IDLE;
            default:                w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr <= 8'h00;
            r_b_sr <= 8'h00;
            r_br   <= 1'b0;
            r_cnt  <= 3'd0;
            r_diff <= 8'h00;
            r_bout <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_a_sr <= ain;
                        r_b_sr <= bin;
                        r_br   <= brin;
                        r_cnt  <= 3'd0;
                    end
                end
                c_SHIFT: begin
                    r_a_sr <= {1'b0, r_a_sr[7:1]};
                    r_b_sr <= {1'b0, r_b_sr[7:1]};
                    r_br   <= w_br_next;
                    r_diff <= {w_d, r_diff[7:1]};
                    r_cnt  <= r_cnt + 3'd1;
                    if (w_last) begin
                        r_bout <= w_br_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;

`ifdef SERIAL_SUB8_OVF_EN
    // On the last shift bit 0 of each shift register holds the original MSB,
    // and w_d is the final diff[7], so no extra sign latches are needed.
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == c_SHIFT && w_last) begin
            r_ovf <= (r_a_sr[0] ^ r_b_sr[0]) & (w_d ^ r_a_sr[0]);
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_sub8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_sub8
//  Brief    : Self-checking bench for serial_sub8: vector table, hand-written
//             corner sequences and randomized ops against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub8;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] ain;
    logic [7:0] bin;
    logic       brin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    int n_pass;
    int n_tot;
    int cyc;
    int last_acc;

    serial_sub8 u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ain       (ain),
        .bin       (bin),
        .brin      (brin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SERIAL_SUB8_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

`ifndef SERIAL_SUB8_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       br;
        logic [7:0] exp_d;
        logic       exp_bo;
        logic       exp_ov;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic: borrow iff the true difference goes negative,
    // overflow iff the signed difference leaves the 8-bit range.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic br,
                         output logic [7:0] d, output logic bo, output logic ov);
        int r;
        int s;
        r  = int'(a) - int'(b) - int'(br);
        s  = int'($signed(a)) - int'($signed(b)) - int'(br);
        d  = 8'(r & 255);
        bo = (r < 0);
        ov = (s < -128) || (s > 127);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic br,
                          input int hold, output logic [7:0] d, output logic bo,
                          output logic ov);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        ain      = a;
        bin      = b;
        brin     = br;
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (last_acc >= 0) begin
            chk("issue_interval_ge_10", {31'd0, (cyc - last_acc) >= 10}, 32'd1);
        end
        last_acc = cyc;
        in_valid = 1'b0;
        ain      = 8'($urandom);
        bin      = 8'($urandom);
        brin     = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'd8);
        d  = diff;
        bo = bout;
        ov = ovf;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       bo;
        logic       ov;
        logic [7:0] ed;
        logic       ebo;
        logic       eov;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbr;
        int         lat;

        n_pass   = 0;
        n_tot    = 0;
        last_acc = -1;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{8'h01, 8'h80, 1'b0, 8'h81, 1'b1, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ain       = 8'h00;
        bin       = 8'h00;
        brin      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_diff",      {24'd0, diff},      32'h00);
        chk("reset_bout",      {31'd0, bout},      32'd0);
        chk("reset_ovf",       {31'd0, ovf},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].br, 0, d, bo, ov);
            chk($sformatf("vec%0d_diff", i), {24'd0, d},  {24'd0, vecs[i].exp_d});
            chk($sformatf("vec%0d_bout", i), {31'd0, bo}, {31'd0, vecs[i].exp_bo});
`ifdef SERIAL_SUB8_OVF_EN
            chk($sformatf("vec%0d_ovf", i),  {31'd0, ov}, {31'd0, vecs[i].exp_ov});
`endif
        end

        // Backpressure: result must hold while in_valid pulses are ignored.
        ain = 8'hA5; bin = 8'h5A; brin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            ain      = 8'($urandom);
            bin      = 8'($urandom);
            brin     = 1'($urandom);
            chk("bp_diff_stable", {24'd0, diff},      32'h4A);
            chk("bp_bout_stable", {31'd0, bout},      32'd0);
            chk("bp_in_ready",    {31'd0, in_ready},  32'd0);
            chk("bp_out_valid",   {31'd0, out_valid}, 32'd1);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
        chk("bp_release_diff_kept", {24'd0, diff},      32'h4A);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_no_queued_op", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a shift.
        ain = 8'h33; bin = 8'h11; brin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("midrst_diff",      {24'd0, diff},      32'h00);
        chk("midrst_bout",      {31'd0, bout},      32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        last_acc = -1;
        #1;
        run_op(8'h10, 8'h01, 1'b0, 0, d, bo, ov);
        chk("postrst_diff", {24'd0, d},  32'h0F);
        chk("postrst_bout", {31'd0, bo}, 32'd0);

        for (int i = 0; i < 1000; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rbr = 1'($urandom);
            model(ra, rb, rbr, ed, ebo, eov);
            run_op(ra, rb, rbr, int'($urandom_range(0, 3)), d, bo, ov);
            chk("rand_diff", {24'd0, d},  {24'd0, ed});
            chk("rand_bout", {31'd0, bo}, {31'd0, ebo});
`ifdef SERIAL_SUB8_OVF_EN
            chk("rand_ovf",  {31'd0, ov}, {31'd0, eov});
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_sub8.md
# serial_sub8

Bit-serial 8-bit subtractor computing `diff = ain - bin - brin` with borrow-out, one bit per clock, LSB first. It is the subtracting counterpart of the 8-bit ripple adder `dut`, which computes `ain + bin + cin`. The identity `ain - bin - brin == ain + ~bin + ~brin` (mod 256), with `bout == ~cout`, lets benches cross-check the two blocks. Operands are accepted over a valid/ready handshake, and results are returned over a valid/ready handshake.

## Interface
Parameters: none. Width is fixed at 8.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: operands present on `ain`, `bin`, `brin`.
- `in_ready` output 1: block can accept operands (high only in IDLE).
- `ain` input 8: minuend.
- `bin` input 8: subtrahend.
- `brin` input 1: borrow-in.
- `out_valid` output 1: `diff` and `bout` are valid.
- `out_ready` input 1: consumer accepts the result.
- `diff` output 8: difference, registered.
- `bout` output 1: borrow-out, registered.
- `ovf` output 1: signed overflow (only with `SERIAL_SUB8_OVF_EN`).

## Operation
State machine with 3 states:
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`=1: latch `ain`, `bin` and `brin` into shift registers `a_sr`, `b_sr` and `br`; clear bit counter `cnt` (3 bits); go to SHIFT.
- **SHIFT**
  - Per cycle: `d = a_sr[0]^b_sr[0]^br`; `br <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0]^b_sr[0]) & br)`.
  - Shift `a_sr` and `b_sr` right by one.
  - Shift `d` into `diff` from the MSB: `diff <= {d, diff[7:1]}`.
  - `cnt++`.
  - When `cnt`==7: `bout <= br_next`; go to DONE.
- **DONE**
  - `out_valid`=1; `diff` and `bout` are held stable.
  - On `out_ready`=1: go to IDLE.

Rules:
- `in_valid` outside IDLE is ignored; no operands are queued.
- Operand inputs are sampled only on the accepting edge and may change afterwards.
- In IDLE, `diff` and `bout` keep the last result, with `out_valid`=0.
- Arithmetic is modulo 256. `bout`=1 iff `ain < bin + brin` (unsigned).
- Edge cases:
  - `0x00 - 0xFF - 1` gives `diff`=0x00, `bout`=1.
  - `0xFF - 0x00 - 0` gives `diff`=0xFF, `bout`=0.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - state=IDLE, `in_ready`=1, `out_valid`=0.
  - `diff`=0x00, `bout`=0, `ovf`=0.
  - `a_sr`, `b_sr`, `br` and `cnt` cleared.
- Reset asserted mid-SHIFT or in DONE: the operation is discarded. The first edge after release may accept new operands.
- Acceptance edge E0 (IDLE, `in_valid`=1): SHIFT runs on edges E1..E8, processing bits 0..7.
- `out_valid` rises after E8, giving a latency of 8 cycles from the acceptance edge.
- If `out_ready`=1 on edge E9, the block returns to IDLE. The next operands can be accepted on E10, so minimum issue interval is 10 cycles.
- `out_ready` held low: DONE persists indefinitely, with outputs stable.
- `in_ready` and `out_valid` are decoded directly from registered state (no combinational path from inputs).

## Configuration
- `SERIAL_SUB8_OVF_EN` defined:
  - Adds output `ovf`: signed two's-complement overflow, `ovf = (ain[7] != bin[7]) & (diff[7] != ain[7])`. It uses the latched `ain[7]`/`bin[7]`.
  - `ovf` is registered on the same edge as `bout`, held through DONE, and reset to 0.
- Not defined: `ovf` port and its logic are absent; all other behaviour is identical.

## Test plan
- `ain`=0x05, `bin`=0x03, `brin`=0, accepted at E0 -> `out_valid` after E8; `diff`=0x02, `bout`=0.
- `ain`=0x03, `bin`=0x05, `brin`=0 -> `diff`=0xFE, `bout`=1. Then `ain`=0x00, `bin`=0x00, `brin`=1 -> `diff`=0xFF, `bout`=1.
- `ain`=0x80, `bin`=0x01, `brin`=0 -> `diff`=0x7F, `bout`=0, `ovf`=1 (with `SERIAL_SUB8_OVF_EN`). Then 0x7F-0x01 -> `diff`=0x7E, `ovf`=0.
- Backpressure: `out_ready`=0 for 5 cycles after `out_valid` -> `diff`/`bout` stable, `in_ready`=0, `in_valid` pulses ignored. `out_ready`=1 -> IDLE next cycle.
- Reset mid-operation: drop `rst_n` after E4 -> immediately `out_valid`=0, `in_ready`=1, `diff`=0x00. Then 0x10-0x01 -> `diff`=0x0F.
- Random 1000 ops, `out_ready` randomly throttled: `diff`/`bout` match the reference model `{~bout, diff} == ain + ~bin + ~brin` (9-bit). Issue interval is never below 10 cycles.
